// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: glyph encodings
// (bits 6:0 = g..a, active-high) and the slot-index width helper.
package seg_pkg;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // Slot index needs at least one bit even for a single-digit display.
  function automatic int idx_w(input int digits);
    return (digits <= 1) ? 1 : $clog2(digits);
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational nibble-to-glyph map; hex_mode selects letters or a dash
// for nibbles 10..15.
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_DASH;
    case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = hex_mode ? GLYPH_A : GLYPH_DASH;
      4'hB: glyph = hex_mode ? GLYPH_B : GLYPH_DASH;
      4'hC: glyph = hex_mode ? GLYPH_C : GLYPH_DASH;
      4'hD: glyph = hex_mode ? GLYPH_D : GLYPH_DASH;
      4'hE: glyph = hex_mode ? GLYPH_E : GLYPH_DASH;
      4'hF: glyph = hex_mode ? GLYPH_F : GLYPH_DASH;
      default: glyph = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with per-frame input snapshot.
// Optional leading-zero blanking is built when SEG_LZB_EN is defined.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int CLK_DIV     = 263158,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  hex_mode,
`ifdef SEG_LZB_EN
  input  logic                  lzb_en,
`endif
  output logic [DIGITS-1:0]     pos,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = idx_w(DIGITS);

  logic [PW-1:0]         pcnt, pcnt_n;
  logic [IW-1:0]         idx, idx_n;
  logic                  run, run_n;
  logic [4*DIGITS-1:0]   sdata, sdata_n;
  logic [DIGITS-1:0]     sdp, sdp_n;
  logic [DIGITS-1:0]     sblank, sblank_n;
  logic                  shex, shex_n;
  logic                  tick, take, wrap;
  logic [3:0]            nib;
  logic                  dp_bit, blank_bit, lz_bit;
  logic [6:0]            glyph, seg7;
  logic [DIGITS-1:0]     pos_n;
  logic [7:0]            seg_n;
`ifdef SEG_LZB_EN
  logic                  slzb, slzb_n;
  logic                  zero_run;
`endif

  seg_glyph_decode u_decode (
    .nibble   (nib),
    .hex_mode (shex_n),
    .glyph    (glyph)
  );

  // Outputs are registered from the next-state view, so pos/seg change on
  // the same edge that advances the slot (one clock after tick).
  always_comb begin
    tick   = (pcnt == PW'(CLK_DIV - 1));
    pcnt_n = tick ? '0 : pcnt + PW'(1);
    run_n  = run | tick;
    idx_n  = idx;
    if (tick) idx_n = (!run || idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    take   = tick && (idx_n == '0);
    wrap   = tick && run && (idx == IW'(DIGITS - 1));

    sdata_n  = take ? data     : sdata;
    sdp_n    = take ? dp       : sdp;
    sblank_n = take ? blank    : sblank;
    shex_n   = take ? hex_mode : shex;

    nib       = 4'h0;
    dp_bit    = 1'b0;
    blank_bit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(idx_n) == i) begin
        nib       = sdata_n[4*i +: 4];
        dp_bit    = sdp_n[i];
        blank_bit = sblank_n[i];
      end
    end

    lz_bit = 1'b0;
`ifdef SEG_LZB_EN
    slzb_n   = take ? lzb_en : slzb;
    zero_run = 1'b1;
    // Walk down from the leftmost digit; digit 0 is never considered.
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run & (sdata_n[4*k +: 4] == 4'h0);
      if (int'(idx_n) == k) lz_bit = zero_run & slzb_n;
    end
`endif

    seg7 = glyph;
    if (blank_bit || lz_bit) seg7 = GLYPH_BLANK;
    seg_n = run_n ? {dp_bit, seg7} : 8'h00;

    pos_n = '0;
    for (int i = 0; i < DIGITS; i++) begin
      pos_n[i] = run_n && (int'(pcnt_n) >= DEAD_CYCLES) && (int'(idx_n) == i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt       <= '0;
      idx        <= '0;
      run        <= 1'b0;
      sdata      <= '0;
      sdp        <= '0;
      sblank     <= '0;
      shex       <= 1'b0;
      pos        <= '0;
      seg        <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      pcnt       <= pcnt_n;
      idx        <= idx_n;
      run        <= run_n;
      sdata      <= sdata_n;
      sdp        <= sdp_n;
      sblank     <= sblank_n;
      shex       <= shex_n;
      pos        <= pos_n;
      seg        <= seg_n;
      frame_done <= wrap;
    end
  end

`ifdef SEG_LZB_EN
  always_ff @(posedge clk) begin
    if (rst) slzb <= 1'b0;
    else     slzb <= slzb_n;
  end
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: a fast no-dead-time instance for glyph,
// snapshot and frame checks, and a dead-time instance for anode timing/reset.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_a, rst_b;
  logic [15:0] data;
  logic [3:0]  dp, blank;
  logic        hex_mode, lzb_en;
  logic [3:0]  pos_a, pos_b;
  logic [7:0]  seg_a, seg_b;
  logic        fd_a, fd_b;

  int n_vec = 0;
  int n_err = 0;

  seg_scan_ctrl #(.DIGITS(4), .CLK_DIV(4), .DEAD_CYCLES(0)) u_a (
    .clk(clk), .rst(rst_a), .data(data), .dp(dp), .blank(blank),
    .hex_mode(hex_mode),
`ifdef SEG_LZB_EN
    .lzb_en(lzb_en),
`endif
    .pos(pos_a), .seg(seg_a), .frame_done(fd_a)
  );

  seg_scan_ctrl #(.DIGITS(4), .CLK_DIV(6), .DEAD_CYCLES(2)) u_b (
    .clk(clk), .rst(rst_b), .data(data), .dp(dp), .blank(blank),
    .hex_mode(hex_mode),
`ifdef SEG_LZB_EN
    .lzb_en(lzb_en),
`endif
    .pos(pos_b), .seg(seg_b), .frame_done(fd_b)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at the negedge of digit 0's first slot cycle; checks one frame of
  // instance A and loads the next inputs during slot chg_slot.
  task automatic check_frame(input string tag,
                             input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3,
                             input logic fd_exp, input int chg_slot,
                             input logic [15:0] nd, input logic nh,
                             input logic [3:0] ndp, input logic [3:0] nbl,
                             input logic nlz);
    logic [7:0] es [4];
    es = '{e0, e1, e2, e3};
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s_pos%0d", tag, d), 32'(pos_a), 32'(1 << d));
      check($sformatf("%s_seg%0d", tag, d), 32'(seg_a), 32'(es[d]));
      check($sformatf("%s_fd%0d", tag, d), 32'(fd_a), (d == 0) ? 32'(fd_exp) : 32'd0);
      if (d == chg_slot) begin
        data = nd; hex_mode = nh; dp = ndp; blank = nbl; lzb_en = nlz;
      end
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    data = 16'h1234; dp = 4'h0; blank = 4'h0; hex_mode = 1'b1; lzb_en = 1'b0;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_pos", 32'(pos_a), 32'd0);
    check("rst_seg", 32'(seg_a), 32'd0);
    check("rst_fd",  32'(fd_a),  32'd0);
    rst_a = 1'b0;

    // First anode lights in the fifth clock period after release.
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      check($sformatf("pre_pos%0d", e), 32'(pos_a), 32'd0);
    end
    @(negedge clk);

    check_frame("f1", 8'h66, 8'h4F, 8'h5B, 8'h06, 1'b0, 0, 16'hABCD, 1'b1, 4'h0, 4'h0, 1'b0);
    check_frame("f2", 8'h5E, 8'h39, 8'h7C, 8'h77, 1'b1, 0, 16'hABCD, 1'b0, 4'h0, 4'h0, 1'b0);
    check_frame("f3", 8'h40, 8'h40, 8'h40, 8'h40, 1'b1, 0, 16'h1111, 1'b1, 4'b0101, 4'b0010, 1'b0);
    check_frame("f4", 8'h86, 8'h00, 8'h86, 8'h06, 1'b1, 0, 16'h1111, 1'b1, 4'h0, 4'h0, 1'b0);
    check_frame("f5", 8'h06, 8'h06, 8'h06, 8'h06, 1'b1, 1, 16'h2222, 1'b1, 4'h0, 4'h0, 1'b0);
    check_frame("f6", 8'h5B, 8'h5B, 8'h5B, 8'h5B, 1'b1, 0, 16'h0045, 1'b1, 4'h0, 4'h0, 1'b1);
`ifdef SEG_LZB_EN
    check_frame("f7", 8'h6D, 8'h66, 8'h00, 8'h00, 1'b1, 0, 16'h0000, 1'b1, 4'h0, 4'h0, 1'b1);
    check_frame("f8", 8'h3F, 8'h00, 8'h00, 8'h00, 1'b1, 0, 16'h1234, 1'b1, 4'h0, 4'h0, 1'b0);
`else
    check_frame("f7", 8'h6D, 8'h66, 8'h3F, 8'h3F, 1'b1, 0, 16'h0000, 1'b1, 4'h0, 4'h0, 1'b1);
    check_frame("f8", 8'h3F, 8'h3F, 8'h3F, 8'h3F, 1'b1, 0, 16'h1234, 1'b1, 4'h0, 4'h0, 1'b0);
`endif

    // Dead-time instance: CLK_DIV=6, two dark cycles per slot.
    @(negedge clk);
    rst_b = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      @(negedge clk);
      check($sformatf("b_pre%0d", e), 32'(pos_b), 32'd0);
    end
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        check($sformatf("b_pos_s%0d_c%0d", s, c), 32'(pos_b), (c >= 2) ? 32'(1 << s) : 32'd0);
        check($sformatf("b_seg_s%0d_c%0d", s, c), 32'(seg_b),
              (s == 0) ? 32'h66 : (s == 1) ? 32'h4F : 32'h5B);
        if (s == 2 && c == 3) break;
      end
    end
    rst_b = 1'b1;
    @(negedge clk);
    check("b_midrst_pos", 32'(pos_b), 32'd0);
    check("b_midrst_seg", 32'(seg_b), 32'd0);
    check("b_midrst_fd",  32'(fd_b),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
